// File: rtl/spi_mx_pkg.sv
// spi_mx_pkg: shared FSM type and constants for the SPI matrix streamer
package spi_mx_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WAIT_CS_LOW, SHIFT, WAIT_CS_HIGH, DONE
  } state_t;
endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: sclk/cs_n synchronisers, edge detect and mode-0 DATA_W-bit output shifter
module spi_tx_shifter
  import spi_mx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              miso_o,
  output logic              cs_fall_o,
  output logic              cs_rise_o,
  output logic              word_done_o,
  output logic              mid_word_o
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [SYNC_STAGES:0] sclk_q, cs_q;
  logic [DATA_W-1:0]    sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 cs_act, s_rise, s_fall;
  assign cs_act      = ~cs_q[SYNC_STAGES-1];
  assign s_rise      = cs_act & sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign s_fall      = cs_act & ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign cs_fall_o   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
  assign cs_rise_o   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
  assign word_done_o = s_rise && cnt_q == CW'(DATA_W - 1);
  assign mid_word_o  = cnt_q != '0;
  assign miso_o      = sr_q[DATA_W-1];
  // A freshly loaded word keeps its MSB through the first falling edge (cnt 0)
  assign sr_d  = load_i ? load_data_i
               : (cs_rise_o || word_done_o) ? '0
               : (s_fall && mid_word_o) ? {sr_q[DATA_W-2:0], 1'b0} : sr_q;
  assign cnt_d = (load_i || cs_rise_o || word_done_o) ? '0
               : s_rise ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      sr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk_i};
      cs_q   <= {cs_q[SYNC_STAGES-1:0], cs_n_i};
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
    end
endmodule

// File: rtl/spi_matrix_streamer.sv
// spi_matrix_streamer: streams a rows x cols result matrix to an SPI host, one element per word
module spi_matrix_streamer
  import spi_mx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_M  = 16,
  parameter int MAX_N  = 16,
  parameter int ADDR_W = $clog2(MAX_M * MAX_N),
  parameter int DIM_W  = $clog2(MAX_M > MAX_N ? MAX_M + 1 : MAX_N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  output logic              miso,
  input  logic              start,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic              col_major,
  input  logic              burst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              frame_abort,
  output logic [ADDR_W:0]   words_sent
);
  state_t            state_q, state_d;
  logic [DIM_W-1:0]  rows_q, cols_q, r_q, c_q, r_d, c_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] buf_q;
  logic [ADDR_W:0]   ws_q;
  logic cm_q, bm_q, pf_q, cap_q, fin_q, busy_q, done_q, abort_q;
  logic cs_fall, cs_rise, word_done, mid_word, load, last, r_end, c_end, word_ok, pf_rd, go;
  spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
    .clk, .rst_n, .sclk_i(sclk), .cs_n_i(cs_n), .load_i(load), .load_data_i(buf_q),
    .miso_o(miso), .cs_fall_o(cs_fall), .cs_rise_o(cs_rise),
    .word_done_o(word_done), .mid_word_o(mid_word)
  );
  assign go      = state_q == IDLE && start;
  assign r_end   = r_q == rows_q - DIM_W'(1);
  assign c_end   = c_q == cols_q - DIM_W'(1);
  assign last    = r_end && c_end;
  assign word_ok = state_q == SHIFT && word_done && !fin_q;
  assign load    = (state_q == WAIT_CS_LOW && cs_fall) || (word_ok && bm_q && !last);
  // Prefetch reads the element after the one now in the shifter
  assign pf_rd   = state_q == SHIFT && pf_q && !last && !fin_q;
  assign r_d     = cm_q ? (r_end ? '0 : r_q + DIM_W'(1)) : (c_end ? r_q + DIM_W'(1) : r_q);
  assign c_d     = cm_q ? (r_end ? c_q + DIM_W'(1) : c_q) : (c_end ? '0 : c_q + DIM_W'(1));
  assign addr_d  = cm_q ? (r_end ? ADDR_W'(c_q) + ADDR_W'(1) : addr_q + ADDR_W'(cols_q))
                        : addr_q + ADDR_W'(1);
  assign mem_rd_en   = state_q == FETCH || pf_rd;
  assign mem_rd_addr = pf_rd ? addr_d : addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_abort = abort_q;
  assign words_sent  = ws_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (start) state_d = (rows == '0 || cols == '0) ? DONE : FETCH;
      FETCH:        state_d = LOAD;
      LOAD:         state_d = WAIT_CS_LOW;
      WAIT_CS_LOW:  if (cs_fall) state_d = SHIFT;
      SHIFT:        if (cs_rise) state_d = fin_q ? DONE : FETCH;
                    else if (word_ok && !bm_q) state_d = WAIT_CS_HIGH;
      WAIT_CS_HIGH: if (cs_rise) state_d = fin_q ? DONE : FETCH;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end
  // An interrupted word is re-fetched from the unadvanced index and re-sent whole
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      ws_q    <= '0;
      cm_q    <= 1'b0;
      bm_q    <= 1'b0;
      pf_q    <= 1'b0;
      cap_q   <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pf_q    <= load;
      cap_q   <= pf_rd;
      done_q  <= state_q == DONE;
      abort_q <= state_q == SHIFT && cs_rise && mid_word && !fin_q;
      busy_q  <= go ? 1'b1 : state_q == DONE ? 1'b0 : busy_q;
      if (state_q == LOAD || cap_q) buf_q <= mem_rd_data;
      if (go) begin
        rows_q <= rows;
        cols_q <= cols;
        cm_q   <= col_major;
        bm_q   <= burst;
        r_q    <= '0;
        c_q    <= '0;
        addr_q <= '0;
        ws_q   <= '0;
        fin_q  <= 1'b0;
      end else if (word_ok) begin
        ws_q <= ws_q + (ADDR_W + 1)'(1);
        if (last) fin_q <= 1'b1;
        else begin
          r_q    <= r_d;
          c_q    <= c_d;
          addr_q <= addr_d;
        end
      end
    end
endmodule

// File: tb/tb_spi_matrix_streamer.sv
// tb_spi_matrix_streamer: SPI host + memory model checking streamed words against a traversal model
module tb_spi_matrix_streamer;
  localparam int DW = 32, AW = 8, DMW = 5;
  logic clk = 0, rst_n = 0, sclk = 0, cs_n = 1, start = 0, col_major = 0, burst = 0;
  logic [DMW-1:0] rows = '0, cols = '0;
  logic miso, mem_rd_en, busy, done, frame_abort;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [AW:0] words_sent;
  logic [DW-1:0] mem [256];
  int n_cmp = 0, n_bad = 0;
  typedef struct { int r; int c; bit cm; bit b; int n_exp; int last_addr; } vec_t;
  vec_t tbl [4];

  spi_matrix_streamer dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .miso(miso), .start(start),
    .rows(rows), .cols(cols), .col_major(col_major), .burst(burst),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done), .frame_abort(frame_abort), .words_sent(words_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int r, input int c, input bit cm, input bit b);
    rows = DMW'(r); cols = DMW'(c); col_major = cm; burst = b; start = 1;
    clks(1);
    start = 0;
  endtask

  task automatic shift(input int n, output logic [31:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[30:0], miso};
      sclk = 1; clks(5); sclk = 0; clks(5);
    end
  endtask

  task automatic cs_up(output int ab, output int dn);
    ab = 0; dn = 0; cs_n = 1;
    for (int i = 0; i < 12; i++) begin
      clks(1);
      ab += int'(frame_abort);
      dn += int'(done);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
  endtask

  // Expected order comes straight from the traversal definition: address r*cols+c
  task automatic run_xfer(input int r, input int c, input bit cm, input bit b, output logic [31:0] last_w);
    logic [31:0] w;
    int q[$];
    int ab, dn, ab_t = 0, dn_t = 0;
    for (int i = 0; i < (cm ? c : r); i++)
      for (int j = 0; j < (cm ? r : c); j++) q.push_back(cm ? j * c + i : i * c + j);
    do_start(r, c, cm, b);
    clks(4);
    last_w = '0;
    if (b) begin
      cs_n = 0; clks(5);
      foreach (q[k]) begin
        shift(32, w);
        chk($sformatf("burst_word%0d", k), w, mem[q[k]]);
        last_w = w;
      end
      shift(8, w);
      chk("burst_tail_zero", w[7:0], 0);
      cs_up(ab, dn); ab_t += ab; dn_t += dn;
    end else
      foreach (q[k]) begin
        cs_n = 0; clks(5);
        shift(32, w);
        chk($sformatf("word%0d", k), w, mem[q[k]]);
        last_w = w;
        cs_up(ab, dn); ab_t += ab; dn_t += dn;
        if (k == 0 && q.size() > 1) begin
          rows = 1; cols = 1; col_major = ~cm; start = 1;
          clks(1);
          start = 0;
        end
      end
    chk("words_sent", words_sent, q.size());
    chk("done_pulses", dn_t, 1);
    chk("no_abort", ab_t, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    logic [31:0] w;
    int ab, dn, rd;
    tbl[0] = '{2, 3, 1'b0, 1'b0, 6, 5};
    tbl[1] = '{2, 3, 1'b1, 1'b0, 6, 5};
    tbl[2] = '{2, 2, 1'b0, 1'b1, 4, 3};
    tbl[3] = '{3, 1, 1'b1, 1'b1, 3, 2};
    fill_pattern();
    clks(3);
    chk("rst_miso", miso, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", frame_abort, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_words", words_sent, 0);
    rst_n = 1;
    clks(2);

    for (int i = 0; i < 4; i++) begin
      run_xfer(tbl[i].r, tbl[i].c, tbl[i].cm, tbl[i].b, w);
      chk($sformatf("tbl%0d_count", i), words_sent, tbl[i].n_exp);
      chk($sformatf("tbl%0d_last", i), w, 32'hA000_0000 + tbl[i].last_addr);
      clks(3);
    end

    // Abort partway through the second word of a 2x2 non-burst transfer
    do_start(2, 2, 0, 0);
    clks(4);
    cs_n = 0; clks(5); shift(32, w);
    chk("abort_w0", w, mem[0]);
    cs_up(ab, dn);
    chk("abort_w0_noab", ab, 0);
    cs_n = 0; clks(5); shift(10, w);
    chk("abort_partial", w[9:0], mem[1][31:22]);
    cs_up(ab, dn);
    chk("abort_pulse", ab, 1);
    chk("abort_ws", words_sent, 1);
    for (int k = 1; k < 4; k++) begin
      cs_n = 0; clks(5); shift(32, w);
      chk($sformatf("abort_resend%0d", k), w, mem[k]);
      cs_up(ab, dn);
    end
    chk("abort_done", dn, 1);
    chk("abort_ws_final", words_sent, 4);
    clks(3);

    // Zero-size matrix
    rd = 0;
    do_start(0, 5, 0, 0);
    rd += int'(mem_rd_en);
    chk("zero_busy", busy, 1);
    chk("zero_done_early", done, 0);
    clks(1);
    rd += int'(mem_rd_en);
    chk("zero_done", done, 1);
    chk("zero_busy_drop", busy, 0);
    chk("zero_miso", miso, 0);
    clks(1);
    rd += int'(mem_rd_en);
    chk("zero_done_pulse", done, 0);
    chk("zero_no_read", rd, 0);

    // Reset in the middle of a burst word
    do_start(2, 2, 0, 1);
    clks(4);
    cs_n = 0; clks(5); shift(40, w);
    rst_n = 0;
    #2;
    chk("mrst_miso", miso, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_abort", frame_abort, 0);
    chk("mrst_rd_en", mem_rd_en, 0);
    chk("mrst_rd_addr", mem_rd_addr, 0);
    chk("mrst_words", words_sent, 0);
    cs_n = 1;
    clks(3);
    rst_n = 1;
    clks(3);
    run_xfer(2, 2, 0, 1, w);

    // Random configurations and memory contents
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      run_xfer($urandom_range(1, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), w);
      clks(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_matrix_streamer.md
# spi_matrix_streamer

Parametrised SPI-slave result streamer for the matrix accelerator. It reads a rows×cols result matrix from a synchronous result memory through a read port and shifts one element per 32-bit SPI word out on miso to the external host. The host clocks the words with sclk/cs_n. Compared with the previous sender, it adds configurable data width, runtime matrix dimensions, row- or column-major traversal, a multi-word burst mode, and mid-word abort recovery.

## Interface
- DATA_W, 32, bits per SPI word / matrix element
- MAX_M, 16, maximum rows
- MAX_N, 16, maximum columns
- ADDR_W, $clog2(MAX_M*MAX_N), result-memory address width
- DIM_W, $clog2(MAX_M>MAX_N?MAX_M+1:MAX_N+1), dimension field width

Ports:
- clk  in  1  system clock; must run at ≥8× sclk
- rst_n  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
- cs_n  in  1  SPI chip select, active low
- miso  out  1  serial data, MSB first
- start  in  1  one-cycle request to begin a transfer; ignored while busy
- rows  in  DIM_W  row count, latched on start
- cols  in  DIM_W  column count, latched on start
- col_major  in  1  0 = row-major traversal, 1 = column-major; latched on start
- burst  in  1  0 = one word per cs_n frame, 1 = all words in one frame; latched on start
- mem_rd_en  out  1  result-memory read strobe
- mem_rd_addr  out  ADDR_W  element (r,c) lives at r*cols+c
- mem_rd_data  in  DATA_W  read data, valid 1 cycle after mem_rd_en
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the transfer completes
- frame_abort  out  1  one-cycle pulse when cs_n rises mid-word
- words_sent  out  ADDR_W+1  count of fully shifted words; cleared on start

## Operation
- Reset values: miso 0, busy 0, done 0, frame_abort 0, mem_rd_en 0, mem_rd_addr 0, words_sent 0, FSM in IDLE, all counters 0.
- FSM states: IDLE → FETCH → LOAD → WAIT_CS_LOW → SHIFT → WAIT_CS_HIGH → (FETCH | DONE) → IDLE.
  - IDLE: on start, latch the configuration and clear words_sent. If rows==0 or cols==0, go to DONE; otherwise go to FETCH.
  - FETCH: assert mem_rd_en for 1 cycle at the current address.
  - LOAD: capture mem_rd_data into the word buffer.
  - WAIT_CS_LOW: on a synchronised cs_n fall, load the shifter from the buffer (miso = MSB) and go to SHIFT.
  - SHIFT: each sclk falling edge shifts the next bit out. The DATA_W-th sclk rising edge completes the word: increment words_sent and advance the index.
  - In SHIFT, the next element is prefetched into the buffer immediately after the shifter loads.
  - Burst mode: the next word loads into the shifter at word completion with no gap. After the last word, miso = 0 for any further edges.
  - Non-burst mode: after word completion, miso = 0 until the cs_n rise. On the cs_n rise, go to FETCH if words remain, else DONE.
  - Burst mode: a cs_n rise after the final word goes to DONE.
  - DONE: pulse done, drop busy, return to IDLE.
- Traversal:
  - Row-major: index order (0,0),(0,1)…(0,cols-1),(1,0)…
  - Column-major: (0,0),(1,0)…(rows-1,0),(0,1)…
  - The address is generated incrementally (+1, or +cols with wrap to c+1); no multiplier.
- Mid-word abort: if cs_n rises with 0 < bits shifted < DATA_W:
  - pulse frame_abort;
  - do not advance the index or words_sent;
  - the same element is re-sent in the next frame, starting from its MSB.
- cs_n rising before any bit has shifted: no abort; the word is retained.
- start while busy: ignored; the latched configuration is unchanged.
- Reset mid-transfer: all state clears immediately; the host must restart framing.

## Timing
- sclk and cs_n pass through 2-flop synchronisers; edges are detected on the synchronised value. Edge-to-action latency is 3 clk cycles.
- Host constraints:
  - ≥4 clk between the cs_n fall and the first sclk rise;
  - sclk high and low phases each ≥4 clk;
  - ≥4 clk of cs_n high between frames.
- Memory read latency is 1 cycle. FETCH→LOAD→WAIT_CS_LOW costs 2 cycles per word in non-burst mode.
- In burst mode the prefetch completes within 3 clk of the shifter load, well before the next word boundary.
- done asserts exactly 1 cycle after the final cs_n rise is detected, or 2 cycles after start for a zero-size matrix.

## Structure
- Package spi_mx_pkg holds:
  - the state_t enum (3-bit);
  - the default DATA_W;
  - the sync-stage count constant.
- Sub-module spi_tx_shifter contains the synchronisers, edge detect, DATA_W shift register, and bit counter.
  - Outputs: cs_fall, cs_rise, word_done, mid_word.
  - Input: load with load_data.
- The top level holds the FSM, address generator, prefetch buffer, and counters.

## Test plan
- 2×3 row-major, non-burst, memory[i]=32'hA000_0000+i → 6 frames carrying A0000000…A0000005 in order; words_sent=6; done pulses once.
- 2×3 column-major, non-burst, same memory → addresses 0,3,1,4,2,5; received words A0000000, A0000003, A0000001, A0000004, A0000002, A0000005.
- 2×2 burst, single cs_n frame of 128 sclk → 4 contiguous words with no miso gap; a further 8 sclk edges shift out zeros; done after cs_n rises.
- Abort: raise cs_n after 10 bits of word 1 → frame_abort pulses; words_sent stays 1; the next frame re-sends word 1 in full.
- rows=0, cols=5, start → no mem_rd_en; done 2 cycles after start; miso stays 0.
- Reset asserted mid-word in burst mode → all outputs return to reset values at once; a new start then transfers correctly from (0,0).
